// File: rtl/usb_rcv_ctrl.sv
// USB receive-side packet controller: tracks sync, data bytes and EOP, drives the
// receive FIFO write strobe and reports clean completion or a sticky packet error.
module usb_rcv_ctrl #(
    parameter int unsigned MAX_BYTES = 64
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       d_edge,
    input  logic       shift_enable,
    input  logic       eop,
    input  logic       byte_received,
    input  logic [7:0] rcv_data,
    output logic       rcving,
    output logic       w_enable,
    output logic       r_error,
    output logic [6:0] byte_count,
    output logic       packet_done
);

    typedef enum logic [3:0] {
        StIdle,
        StRcvSync,
        StCheckSync,
        StReceive,
        StStore,
        StEopCheck,
        StEopWait,
        StErrWait,
        StErrEidle,
        StErrIdle
    } state_e;

    state_e     state_q, state_d;
    logic [6:0] count_q, count_d;
    logic       done_q, done_d;
    logic       seop;
    logic       room;

    assign seop = eop & shift_enable;
    // Count saturates at 127, so a MAX_BYTES above that never reports overflow.
    assign room = 32'(count_q) < MAX_BYTES;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= StIdle;
            count_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        done_d  = 1'b0;
        case (state_q)
            StIdle: begin
                if (d_edge) begin
                    state_d = StRcvSync;
                    count_d = '0;
                end
            end
            StRcvSync: begin
                if (byte_received) state_d = StCheckSync;
                else if (seop)     state_d = StErrEidle;
            end
            StCheckSync: state_d = (rcv_data == 8'h80) ? StReceive : StErrWait;
            StReceive: begin
                if (byte_received) state_d = room ? StStore : StErrWait;
                else if (seop)     state_d = StErrEidle;
            end
            StStore: begin
                state_d = StEopCheck;
                count_d = (count_q == 7'd127) ? count_q : count_q + 7'd1;
            end
            StEopCheck: begin
                if (shift_enable) state_d = eop ? StEopWait : StReceive;
            end
            StEopWait: begin
                if (d_edge) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            StErrWait: begin
                if (seop) state_d = StErrEidle;
            end
            StErrEidle: begin
                if (d_edge) state_d = StErrIdle;
            end
            StErrIdle: begin
                if (d_edge) begin
                    state_d = StRcvSync;
                    count_d = '0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign rcving      = !(state_q inside {StIdle, StErrIdle});
    assign r_error     = state_q inside {StErrWait, StErrEidle, StErrIdle};
    assign w_enable    = (state_q == StStore);
    assign byte_count  = count_q;
    assign packet_done = done_q;

endmodule
